imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 43 ++++
 rtl/imm_decode.sv | 58 +++++
 rtl/imm_gen_pipe.sv | 154 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// ----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate generator pipeline: the 3-bit
// instruction format code, the RV32I base opcodes, the default immediate
// width and the state encoding of the output/skid stage.
// ----------------------------------------------------------------------------
package imm_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Format code reported with every decoded instruction; NONE doubles as
   // the "opcode not recognised" marker and is also the reset value.
   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_R    = 3'd1,
      FMT_I    = 3'd2,
      FMT_S    = 3'd3,
      FMT_B    = 3'd4,
      FMT_U    = 3'd5,
      FMT_J    = 3'd6
   } immFmtT;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Occupancy of the two-entry output stage: nothing held, only the output
   // register held, or output register plus skid register held.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipeStateT;

endpackage

// File: rtl/imm_decode.sv
// ----------------------------------------------------------------------------
// imm_decode
// Purely combinational RV32I immediate decoder.
// Ports:
//   instr   in   32    instruction word
//   imm     out  XLEN  immediate, sign-extended to XLEN (0 for R / NONE)
//   fmt     out  3     format code (immFmtT)
//   illegal out  1     opcode is not part of the RV32I base set
// ----------------------------------------------------------------------------
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   immFmtT             fmtSel;
   logic signed [31:0] imm32;

   // Classify the opcode into one of the immediate formats. FENCE and SYSTEM
   // carry an I-shaped field, so they share the I path with loads and ALU-imm.
   always_comb begin
      fmtSel = FMT_NONE;
      case (instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmtSel = FMT_I;
         OP_STORE:                                      fmtSel = FMT_S;
         OP_BRANCH:                                     fmtSel = FMT_B;
         OP_LUI, OP_AUIPC:                              fmtSel = FMT_U;
         OP_JAL:                                        fmtSel = FMT_J;
         OP_REG:                                        fmtSel = FMT_R;
         default:                                       fmtSel = FMT_NONE;
      endcase
   end

   // Reassemble the scattered immediate bits into a 32-bit signed value.
   // Widening to XLEN afterwards is a signed cast, so the upper half of a
   // 64-bit result is filled with the sign for every format, U included.
   always_comb begin
      imm32 = '0;
      case (fmtSel)
         FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U: imm32 = {instr[31:12], 12'b0};
         FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm     = XLEN'(imm32);
   assign fmt     = fmtSel;
   assign illegal = (fmtSel == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Decodes RV32I immediates behind a valid/ready handshake with an output
// register plus one skid register. One cycle of latency, one result per
// cycle when the consumer is ready, and in_ready depends only on state.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous discard of all held entries
//   in_valid/in_ready  input handshake; in_instr (32), in_tag (TAG_W)
//   out_valid/out_ready output handshake
//   out_imm (XLEN), out_fmt (3), out_illegal, out_tag (TAG_W)
// ----------------------------------------------------------------------------
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0]  decImm;
   logic [2:0]       decFmt;
   logic             decIllegal;

   logic [XLEN-1:0]  skidImm;
   logic [2:0]       skidFmt;
   logic             skidIllegal;
   logic [TAG_W-1:0] skidTag;

   pipeStateT state;
   pipeStateT nextState;
   logic      inXfer;
   logic      outXfer;
   logic      loadOutFromIn;
   logic      loadOutFromSkid;
   logic      loadSkid;

   imm_decode #(
      .XLEN(XLEN)
   ) decodeInst (
      .instr  (in_instr),
      .imm    (decImm),
      .fmt    (decFmt),
      .illegal(decIllegal)
   );

   // Both handshake flags come straight from the state register, so neither
   // ready nor valid has a combinational path from the opposite side.
   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign inXfer    = in_valid & in_ready;
   assign outXfer   = out_valid & out_ready;

   // Occupancy register. Reset empties the stage immediately, without
   // waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= nextState;
      end
   end

   // Next occupancy plus the steering of data into the two registers.
   // Flush is checked first so it overrides any transfer in the same cycle;
   // a simultaneous in/out transfer in ONE simply replaces the output entry.
   always_comb begin
      nextState       = state;
      loadOutFromIn   = 1'b0;
      loadOutFromSkid = 1'b0;
      loadSkid        = 1'b0;
      if (flush) begin
         nextState = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (inXfer) begin
                  nextState     = ST_ONE;
                  loadOutFromIn = 1'b1;
               end
            end
            ST_ONE: begin
               if (inXfer && outXfer) begin
                  loadOutFromIn = 1'b1;
               end else if (inXfer) begin
                  nextState = ST_FULL;
                  loadSkid  = 1'b1;
               end else if (outXfer) begin
                  nextState = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (outXfer) begin
                  nextState       = ST_ONE;
                  loadOutFromSkid = 1'b1;
               end
            end
            default: nextState = ST_EMPTY;
         endcase
      end
   end

   // Output register. It only changes on a load, which keeps the presented
   // result stable while the consumer stalls. The skid entry takes priority
   // because it is always older than anything arriving at the input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_imm     <= '0;
         out_fmt     <= FMT_NONE;
         out_illegal <= 1'b0;
         out_tag     <= '0;
      end else if (loadOutFromSkid) begin
         out_imm     <= skidImm;
         out_fmt     <= skidFmt;
         out_illegal <= skidIllegal;
         out_tag     <= skidTag;
      end else if (loadOutFromIn) begin
         out_imm     <= decImm;
         out_fmt     <= decFmt;
         out_illegal <= decIllegal;
         out_tag     <= in_tag;
      end
   end

   // Skid register. It catches the one instruction accepted while the output
   // is stalled; its validity is tracked by the FULL state alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skidImm     <= '0;
         skidFmt     <= FMT_NONE;
         skidIllegal <= 1'b0;
         skidTag     <= '0;
      end else if (loadSkid) begin
         skidImm     <= decImm;
         skidFmt     <= decFmt;
         skidIllegal <= decIllegal;
         skidTag     <= in_tag;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Self-checking bench for imm_gen_pipe. A 32-bit and a 64-bit instance see
// the same stimulus. Expected results come from a fixed vector table, from
// hand-written handshake sequences, and from a queue-based reference model
// that decodes immediates with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;
   import imm_pkg::*;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        inReady32;
   logic        outValid32;
   logic [31:0] outImm32;
   logic [2:0]  outFmt32;
   logic        outIllegal32;
   logic [31:0] outTag32;

   logic        inReady64;
   logic        outValid64;
   logic [63:0] outImm64;
   logic [2:0]  outFmt64;
   logic        outIllegal64;
   logic [31:0] outTag64;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [31:0] tag;
   } entryT;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] expImm;
      logic [2:0]  expFmt;
      logic        expIll;
   } vecT;

   entryT modelQ[$];
   vecT   vecs[10];
   int    numCompared;
   int    numMismatched;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (inReady32),
      .in_instr   (in_instr),
      .in_tag     (in_tag),
      .out_valid  (outValid32),
      .out_ready  (out_ready),
      .out_imm    (outImm32),
      .out_fmt    (outFmt32),
      .out_illegal(outIllegal32),
      .out_tag    (outTag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (inReady64),
      .in_instr   (in_instr),
      .in_tag     (in_tag),
      .out_valid  (outValid64),
      .out_ready  (out_ready),
      .out_imm    (outImm64),
      .out_fmt    (outFmt64),
      .out_illegal(outIllegal64),
      .out_tag    (outTag64)
   );

   // Free-running clock; inputs change and outputs are sampled on the
   // falling edge, away from the active rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decoder: evaluates the immediate as a signed integer built
   // from weighted bit fields, then wraps it into the value range of its
   // field width.
   function automatic entryT refDecode(input logic [31:0] instr, input logic [31:0] tag);
      entryT  e;
      longint v;
      e.tag = tag;
      e.ill = 1'b0;
      v     = 0;
      case (instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
            e.fmt = FMT_I;
            v = longint'(instr[31:20]);
            if (v >= 2048) v = v - 4096;
         end
         7'b0100011: begin
            e.fmt = FMT_S;
            v = longint'(instr[31:25]) * 32 + longint'(instr[11:7]);
            if (v >= 2048) v = v - 4096;
         end
         7'b1100011: begin
            e.fmt = FMT_B;
            v = longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048
              + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
            if (v >= 4096) v = v - 8192;
         end
         7'b0110111, 7'b0010111: begin
            e.fmt = FMT_U;
            v = longint'(instr[31:12]) * 4096;
            if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
         end
         7'b1101111: begin
            e.fmt = FMT_J;
            v = longint'(instr[31]) * 1048576 + longint'(instr[19:12]) * 4096
              + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
            if (v >= 1048576) v = v - 2097152;
         end
         7'b0110011: begin
            e.fmt = FMT_R;
         end
         default: begin
            e.fmt = FMT_NONE;
            e.ill = 1'b1;
         end
      endcase
      e.imm = 64'(v);
      return e;
   endfunction

   // Single comparison; every check in the bench goes through here.
   task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, let the rising edge happen, advance the
   // queue model with the transfers that edge performs, and return on the
   // following falling edge.
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] tag,
                                input logic rdy, input logic fl);
      logic inX;
      logic outX;
      in_valid  = v;
      in_instr  = instr;
      in_tag    = tag;
      out_ready = rdy;
      flush     = fl;
      inX  = v && (modelQ.size() < 2) && !fl;
      outX = (modelQ.size() > 0) && rdy && !fl;
      @(posedge clk);
      if (fl) begin
         modelQ.delete();
      end else begin
         if (outX) void'(modelQ.pop_front());
         if (inX) modelQ.push_back(refDecode(instr, tag));
      end
      @(negedge clk);
   endtask

   // Compare both instances against the head of the model queue.
   task automatic checkOutput(input string name);
      checkValue({name, "_out_valid"}, 64'(outValid32), 64'(modelQ.size() > 0));
      checkValue({name, "_in_ready"}, 64'(inReady32), 64'(modelQ.size() < 2));
      checkValue({name, "_out_valid64"}, 64'(outValid64), 64'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
         checkValue({name, "_imm32"}, 64'(outImm32), 64'(modelQ[0].imm[31:0]));
         checkValue({name, "_imm64"}, outImm64, modelQ[0].imm);
         checkValue({name, "_fmt"}, 64'(outFmt32), 64'(modelQ[0].fmt));
         checkValue({name, "_illegal"}, 64'(outIllegal32), 64'(modelQ[0].ill));
         checkValue({name, "_tag"}, 64'(outTag32), 64'(modelQ[0].tag));
      end
   endtask

   // Outputs of the 32-bit instance right after reset.
   task automatic checkResetState(input string name);
      checkValue({name, "_out_valid"}, 64'(outValid32), 64'd0);
      checkValue({name, "_in_ready"}, 64'(inReady32), 64'd1);
      checkValue({name, "_imm"}, 64'(outImm32), 64'd0);
      checkValue({name, "_fmt"}, 64'(outFmt32), 64'(FMT_NONE));
      checkValue({name, "_illegal"}, 64'(outIllegal32), 64'd0);
      checkValue({name, "_tag"}, 64'(outTag32), 64'd0);
      checkValue({name, "_imm64"}, outImm64, 64'd0);
   endtask

   // Main test sequence.
   initial begin
      logic [6:0]  opPool[12];
      logic [31:0] r;
      logic [6:0]  op;

      numCompared   = 0;
      numMismatched = 0;

      vecs[0] = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I,    1'b0};
      vecs[1] = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S,    1'b0};
      vecs[2] = '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, FMT_B,    1'b0};
      vecs[3] = '{32'h123452B7, 64'h0000_0000_1234_5000, FMT_U,    1'b0};
      vecs[4] = '{32'h001000EF, 64'h0000_0000_0000_0800, FMT_J,    1'b0};
      vecs[5] = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, FMT_U,    1'b0};
      vecs[6] = '{32'h00000033, 64'h0000_0000_0000_0000, FMT_R,    1'b0};
      vecs[7] = '{32'h0000007F, 64'h0000_0000_0000_0000, FMT_NONE, 1'b1};
      vecs[8] = '{32'h7FF00067, 64'h0000_0000_0000_07FF, FMT_I,    1'b0};
      vecs[9] = '{32'h80000017, 64'hFFFF_FFFF_8000_0000, FMT_U,    1'b0};

      opPool = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
                 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111, 7'b1110011, 7'b0000000};

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkResetState("reset");
      rst = 1'b0;
      @(negedge clk);

      // Table vectors back to back with the consumer always ready: each
      // result appears one cycle after it is offered and the stage never fills.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, vecs[i].instr, 32'h100 + i, 1'b1, 1'b0);
         checkValue($sformatf("tbl%0d_valid", i), 64'(outValid32), 64'd1);
         checkValue($sformatf("tbl%0d_imm32", i), 64'(outImm32), 64'(vecs[i].expImm[31:0]));
         checkValue($sformatf("tbl%0d_imm64", i), outImm64, vecs[i].expImm);
         checkValue($sformatf("tbl%0d_fmt", i), 64'(outFmt32), 64'(vecs[i].expFmt));
         checkValue($sformatf("tbl%0d_illegal", i), 64'(outIllegal32), 64'(vecs[i].expIll));
         checkValue($sformatf("tbl%0d_tag", i), 64'(outTag32), 64'(32'h100 + i));
         checkOutput($sformatf("tbl%0d_model", i));
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkValue("drain_valid", 64'(outValid32), 64'd0);

      // Two inputs against a stalled consumer: the second lands in the skid
      // register, in_ready drops, and both leave in order once released.
      applyStimulus(1'b1, 32'hFFF00093, 32'hA1, 1'b0, 1'b0);
      checkValue("stall_first_ready", 64'(inReady32), 64'd1);
      checkValue("stall_first_tag", 64'(outTag32), 64'hA1);
      applyStimulus(1'b1, 32'h123452B7, 32'hB2, 1'b0, 1'b0);
      checkValue("stall_full_ready", 64'(inReady32), 64'd0);
      checkValue("stall_full_tag", 64'(outTag32), 64'hA1);
      checkValue("stall_full_imm", 64'(outImm32), 64'hFFFF_FFFF);
      applyStimulus(1'b1, 32'h00000033, 32'hC3, 1'b0, 1'b0);
      checkValue("stall_hold_imm", 64'(outImm32), 64'hFFFF_FFFF);
      checkValue("stall_hold_fmt", 64'(outFmt32), 64'(FMT_I));
      checkValue("stall_hold_tag", 64'(outTag32), 64'hA1);
      checkOutput("stall_hold");
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkValue("release_tag", 64'(outTag32), 64'hB2);
      checkValue("release_imm", 64'(outImm32), 64'h1234_5000);
      checkValue("release_ready", 64'(inReady32), 64'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkValue("release_empty", 64'(outValid32), 64'd0);

      // Flush while full with a new offer in the same cycle: everything,
      // including the offered instruction, disappears.
      applyStimulus(1'b1, 32'hFE112E23, 32'hD1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hFE000CE3, 32'hD2, 1'b0, 1'b0);
      checkValue("preflush_ready", 64'(inReady32), 64'd0);
      applyStimulus(1'b1, 32'h001000EF, 32'hD3, 1'b1, 1'b1);
      checkValue("flush_valid", 64'(outValid32), 64'd0);
      checkValue("flush_ready", 64'(inReady32), 64'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkValue("postflush_valid", 64'(outValid32), 64'd0);

      // Asynchronous reset while full: outputs clear before the next edge,
      // and an offer held across an edge during reset is not taken.
      applyStimulus(1'b1, 32'hFE112E23, 32'hE1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hFE000CE3, 32'hE2, 1'b0, 1'b0);
      checkValue("prereset_ready", 64'(inReady32), 64'd0);
      #2 rst = 1'b1;
      #1 checkResetState("async_reset");
      modelQ.delete();
      in_valid  = 1'b1;
      in_instr  = 32'h123452B7;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkResetState("reset_hold");
      rst      = 1'b0;
      in_valid = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("after_reset");

      // Random traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         r  = $urandom();
         op = opPool[$urandom_range(0, 11)];
         if (op == 7'b0000000) op = r[6:0];
         applyStimulus($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom(),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
         checkOutput($sformatf("rand%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
